// File: rtl/dwa_rotator_if.sv
// dwa_rotator_if: sample/element-select bundle between decoder, DWA stage and switch array
// master drives therm/in_valid/dem_en and observes elem/out_valid/ptr/err; slave is the reverse.
interface dwa_rotator_if;
  logic [14:0] therm;
  logic        in_valid;
  logic        dem_en;
  logic [14:0] elem;
  logic        out_valid;
  logic [3:0]  ptr;
  logic        err;
  modport master(output therm, in_valid, dem_en, input elem, out_valid, ptr, err);
  modport slave(input therm, in_valid, dem_en, output elem, out_valid, ptr, err);
endinterface

// File: rtl/dwa_rotator.sv
// dwa_rotator: data-weighted-averaging element rotator for a 15-element unit DAC
// Ports: clk, rst (async active-high); bus.therm/in_valid/dem_en in, bus.elem/out_valid/ptr/err out.
// Macro DWA_THERM_CHECK_EN builds the sticky malformed-thermometer flag; otherwise err is tied low.
module dwa_rotator (
  input  logic         clk,
  input  logic         rst,
  dwa_rotator_if.slave bus
);
  logic [14:0] elem_q, elem_d, mask, rot;
  logic [3:0]  ptr_q, ptr_d, cnt;
  logic [4:0]  sum;
  logic        vld_q;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 15; i++) cnt = cnt + {3'b0, bus.therm[i]};
    mask = 15'((16'd1 << cnt) - 16'd1);
    // ptr is at most 14, so the right shift is 1..15 and the rotate never degenerates
    rot = (mask << ptr_q) | (mask >> (4'd15 - ptr_q));
    sum = {1'b0, ptr_q} + {1'b0, cnt};
    elem_d = !bus.in_valid ? elem_q : bus.dem_en ? rot : bus.therm;
    ptr_d = !(bus.in_valid && bus.dem_en) ? ptr_q : sum >= 5'd15 ? 4'(sum - 5'd15) : sum[3:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      elem_q <= '0;
      ptr_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      elem_q <= elem_d;
      ptr_q  <= ptr_d;
      vld_q  <= bus.in_valid;
    end
  assign bus.elem      = elem_q;
  assign bus.ptr       = ptr_q;
  assign bus.out_valid = vld_q;
`ifdef DWA_THERM_CHECK_EN
  logic err_q;
  // a thermometer code plus one is a power of two, so it shares no bits with the code
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else err_q <= err_q | (bus.in_valid && |(bus.therm & (bus.therm + 15'd1)));
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_dwa_rotator.sv
// tb_dwa_rotator: scoreboard bench for dwa_rotator against a set-based DWA model
module tb_dwa_rotator;
  typedef struct {
    logic [14:0] elem;
    logic [3:0]  ptr;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int mp = 0;
  logic merr = 1'b0;
  logic [14:0] hold_elem = '0;
  logic [3:0] hold_ptr = '0;
  logic hold_err = 1'b0;
  dwa_rotator_if bus();
  dwa_rotator dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit is_therm(input logic [14:0] t);
    for (int k = 0; k <= 15; k++) if (t == 15'((32'd1 << k) - 1)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic send(input logic v, input logic d, input logic [14:0] t);
    logic [14:0] e;
    int c;
    @(negedge clk);
    bus.in_valid = v;
    bus.dem_en = d;
    bus.therm = t;
    if (v) begin
      c = $countones(t);
      if (d) begin
        e = '0;
        for (int k = 0; k < c; k++) e[(mp + k) % 15] = 1'b1;
        mp = (mp + c) % 15;
      end else e = t;
`ifdef DWA_THERM_CHECK_EN
      if (!is_therm(t)) merr = 1'b1;
`endif
      q.push_back('{e, 4'(mp), merr});
    end
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_elem", 32'(bus.elem), 0);
    chk("rst_ptr", 32'(bus.ptr), 0);
    chk("rst_vld", 32'(bus.out_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    bus.in_valid = 1'b0;
    q.delete();
    mp = 0;
    merr = 1'b0;
    hold_elem = '0;
    hold_ptr = '0;
    hold_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("ptr_range", 32'(bus.ptr == 4'd15), 0);
        if (bus.out_valid && q.size() > 0) begin
          e = q.pop_front();
          chk("elem", 32'(bus.elem), 32'(e.elem));
          chk("ptr", 32'(bus.ptr), 32'(e.ptr));
          chk("err", 32'(bus.err), 32'(e.err));
          hold_elem = e.elem;
          hold_ptr = e.ptr;
          hold_err = e.err;
        end else begin
          chk("hold_elem", 32'(bus.elem), 32'(hold_elem));
          chk("hold_ptr", 32'(bus.ptr), 32'(hold_ptr));
          chk("hold_err", 32'(bus.err), 32'(hold_err));
        end
      end
    end
  end
  initial begin
    int c;
    bus.in_valid = 1'b0;
    bus.dem_en = 1'b0;
    bus.therm = '0;
    do_reset();
    send(1, 1, 15'h0007);
    send(1, 1, 15'h000F);
    send(1, 1, 15'h03FF);
    send(1, 1, 15'h7FFF);
    send(1, 1, 15'h0000);
    send(1, 0, 15'h001F);
    send(1, 1, 15'h0001);
    send(0, 1, 15'h7FFF);
    send(1, 1, 15'h0007);
    send(0, 1, 15'h0001);
    send(1, 1, 15'h0007);
    send(0, 0, 15'h03FF);
    send(1, 1, 15'h00FF);
    do_reset();
    send(1, 1, 15'h0003);
    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, 15);
      send($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 15'((32'd1 << c) - 1));
    end
    send(0, 1, 15'h0000);
    do_reset();
    send(1, 1, 15'h0005);
    send(1, 1, 15'h0007);
    send(0, 1, 15'h0000);
    send(1, 1, 15'h007F);
    send(1, 0, 15'h0A50);
    send(0, 1, 15'h0000);
    do_reset();
    send(1, 1, 15'h0001);
    send(0, 1, 15'h0000);
    send(0, 1, 15'h0000);
    @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
